// File: rtl/adler32_pkg.sv
// Shared constants for the streaming Adler-32 checksum engine.
package adler32_pkg;

  localparam int unsigned ADLER_W = 16;
  localparam int unsigned SUM_W   = 2 * ADLER_W;

  localparam logic [ADLER_W-1:0] ADLER_MOD    = 16'd65521;
  localparam logic [ADLER_W-1:0] ADLER_A_INIT = 16'd1;
  localparam logic [ADLER_W-1:0] ADLER_B_INIT = 16'd0;

endpackage : adler32_pkg

// File: rtl/adler32_modadd.sv
// Combinational (a + b) mod MOD for operands already below MOD.
module adler32_modadd
  import adler32_pkg::*;
#(
  parameter logic [ADLER_W-1:0] MOD = ADLER_MOD
) (
  input  logic [ADLER_W-1:0] a_i,
  input  logic [ADLER_W-1:0] b_i,
  output logic [ADLER_W-1:0] sum_c_o
);

  localparam int unsigned RAW_W = ADLER_W + 1;

  logic [RAW_W-1:0] raw_c;

  // Both operands < MOD, so a single conditional subtract fully reduces the sum.
  always_comb begin
    raw_c = RAW_W'(a_i) + RAW_W'(b_i);
    if (raw_c >= RAW_W'(MOD)) begin
      sum_c_o = ADLER_W'(raw_c - RAW_W'(MOD));
    end else begin
      sum_c_o = raw_c[ADLER_W-1:0];
    end
  end

endmodule : adler32_modadd

// File: rtl/adler32.sv
// Streaming Adler-32 engine: one byte per clock, registered {B,A} on the last byte.
module adler32
  import adler32_pkg::*;
#(
  parameter int unsigned MOD = 65521
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             data_valid,
  input  logic [7:0]       data,
  input  logic             last_data,
  output logic             checksum_valid,
  output logic [SUM_W-1:0] checksum
);

  logic [ADLER_W-1:0] a_q, a_d;
  logic [ADLER_W-1:0] b_q, b_d;
  logic [SUM_W-1:0]   checksum_q, checksum_d;
  logic               valid_q, valid_d;

  logic [ADLER_W-1:0] a_next_c;
  logic [ADLER_W-1:0] b_next_c;

  // A is reduced first; B accumulates the already-updated A in the same cycle.
  adler32_modadd #(.MOD(ADLER_W'(MOD))) u_add_a (
    .a_i     (a_q),
    .b_i     (ADLER_W'(data)),
    .sum_c_o (a_next_c)
  );

  adler32_modadd #(.MOD(ADLER_W'(MOD))) u_add_b (
    .a_i     (b_q),
    .b_i     (a_next_c),
    .sum_c_o (b_next_c)
  );

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    checksum_d = checksum_q;
    valid_d    = 1'b0;
    if (data_valid) begin
      if (last_data) begin
        a_d        = ADLER_A_INIT;
        b_d        = ADLER_B_INIT;
        checksum_d = {b_next_c, a_next_c};
        valid_d    = 1'b1;
      end else begin
        a_d = a_next_c;
        b_d = b_next_c;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      a_q        <= ADLER_A_INIT;
      b_q        <= ADLER_B_INIT;
      checksum_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      checksum_q <= checksum_d;
      valid_q    <= valid_d;
    end
  end

  assign checksum       = checksum_q;
  assign checksum_valid = valid_q;

endmodule : adler32

// File: tb/tb_adler32.sv
// Self-checking bench for adler32: directed RFC vectors plus random messages vs a closed-form model.
module tb_adler32;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [7:0]  data = '0;
  logic        last_data = 1'b0;
  logic        checksum_valid;
  logic [31:0] checksum;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned n_pulses = 0;
  int unsigned n_expected_pulses = 0;

  logic [31:0] exp_q[$];
  logic [31:0] hold_val = '0;
  bit          mon_en = 1'b0;
  bit          hold_en = 1'b0;

  typedef byte unsigned msg_t[$];

  adler32 #(.MOD(65521)) dut (
    .clock          (clock),
    .rst            (rst),
    .data_valid     (data_valid),
    .data           (data),
    .last_data      (last_data),
    .checksum_valid (checksum_valid),
    .checksum       (checksum)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Closed form: A = 1 + sum(d_i), B = n + sum((n-i) * d_i), i from 0.
  function automatic logic [31:0] ref_adler(input msg_t m);
    longint unsigned sa = 1;
    longint unsigned sb = 0;
    longint unsigned n = longint'(m.size());
    for (int i = 0; i < m.size(); i++) begin
      sa += longint'(m[i]);
      sb += (n - longint'(i)) * longint'(m[i]);
    end
    sb += n;
    return {16'(sb % 65521), 16'(sa % 65521)};
  endfunction

  function automatic msg_t str2msg(input string s);
    msg_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(byte'(s[i]));
    return q;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic send_msg(input msg_t m, input int unsigned max_gap, input logic [31:0] exp);
    exp_q.push_back(exp);
    n_expected_pulses++;
    for (int i = 0; i < m.size(); i++) begin
      int unsigned gap = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
      repeat (gap) begin
        data_valid = 1'b0;
        data       = 8'($urandom);
        last_data  = 1'($urandom);
        @(posedge clock); #1;
      end
      data_valid = 1'b1;
      data       = m[i];
      last_data  = (i == m.size() - 1);
      @(posedge clock); #1;
    end
    data_valid = 1'b0;
    last_data  = 1'b0;
  endtask

  task automatic apply_reset(input int unsigned cycles);
    hold_en = 1'b0;
    rst = 1'b1;
    repeat (cycles) begin @(posedge clock); #1; end
    rst = 1'b0;
    hold_val = '0;
    @(negedge clock);
    check("reset_checksum", checksum, 32'h0000_0000);
    check("reset_valid", 32'(checksum_valid), 32'd0);
    hold_en = 1'b1;
  endtask

  // Every pulse must match the oldest outstanding expectation; between pulses the result must hold.
  always @(negedge clock) begin
    if (mon_en) begin
      if (checksum_valid) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          check("spurious_pulse", checksum, 32'hxxxx_xxxx);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("checksum", checksum, e);
          hold_val = e;
        end
      end else if (hold_en && !rst) begin
        check("hold", checksum, hold_val);
      end
    end
  end

  initial begin
    msg_t m;
    msg_t ff300;

    @(posedge clock); #1;
    mon_en = 1'b1;
    apply_reset(2);

    send_msg(str2msg("Hello"), 9, 32'h058C01F5);
    send_msg(str2msg("a"), 0, 32'h00620062);
    send_msg(str2msg("Wikipedia"), 0, 32'h11E60398);

    for (int i = 0; i < 300; i++) ff300.push_back(8'hFF);
    send_msg(ff300, 0, 32'hB90F2AE4);

    send_msg(str2msg("Hello"), 0, 32'h058C01F5);
    send_msg(str2msg("Hello"), 0, 32'h058C01F5);
    repeat (2) begin @(posedge clock); #1; end

    // Abort a message after 3 bytes; reset wins even with a byte presented.
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data       = 8'($urandom);
      last_data  = 1'b0;
      @(posedge clock); #1;
    end
    data_valid = 1'b1;
    last_data  = 1'b1;
    apply_reset(1);
    data_valid = 1'b0;
    last_data  = 1'b0;
    @(posedge clock); #1;
    send_msg(str2msg("a"), 0, 32'h00620062);

    for (int t = 0; t < 12; t++) begin
      int unsigned len = $urandom_range(60, 1);
      m.delete();
      for (int i = 0; i < len; i++) m.push_back(8'($urandom));
      send_msg(m, (t % 3 == 0) ? 0 : 4, ref_adler(m));
    end

    m.delete();
    for (int i = 0; i < 400; i++) m.push_back(8'($urandom_range(255, 200)));
    send_msg(m, 0, ref_adler(m));

    repeat (4) begin @(posedge clock); #1; end
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    check("pulse_count", 32'(n_pulses), 32'(n_expected_pulses));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adler32

// File: doc/adler32.md
# adler32

Streaming Adler-32 checksum engine (RFC 1950). Consumes one byte per clock when `data_valid` is high and accumulates the A/B sums modulo 65521. When the byte marked `last_data` is accepted, it presents the 32-bit checksum `{B,A}` with a one-cycle `checksum_valid` strobe. It sits between a byte-stream source and a downstream integrity checker; there is no back-pressure.

## Interface
- `MOD` — 65521 — Adler modulus (largest prime < 2^16); not intended to be overridden.
- `clock` input 1 — sole clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `data_valid` input 1 — `data` is valid this cycle; consume one byte.
- `data` input 8 — message byte.
- `last_data` input 1 — qualified by `data_valid`; marks the final byte of the message.
- `checksum_valid` output 1 — one-cycle pulse; `checksum` holds a completed result.
- `checksum` output 32 — `{B[15:0], A[15:0]}` of the most recently completed message.

## Operation
- Running state: `A` and `B`, 16 bits each. Idle/initial values are A=1, B=0.
- Accepted byte (`data_valid`=1):
  - A' = (A + data) mod 65521.
  - B' = (B + A') mod 65521.
- Arithmetic widths:
  - A + data needs 17 bits; B + A' needs 17 bits.
  - Each reduction is one conditional subtract: if sum ≥ 65521, subtract 65521. Both operands are always < 65521, so one subtract is enough.
- Accepted byte with `last_data`=1:
  - `checksum` <= {B', A'}; `checksum_valid` <= 1.
  - A <= 1 and B <= 0, so the next message starts clean with no idle gap.
- `data_valid`=0: state holds. `data` and `last_data` are ignored (don't-care).
- Gaps of any length between bytes are legal; the message continues.
- `checksum` holds its value until the next completion or reset.
- Zero-length messages are not supported; `last_data` must accompany a real byte.

## Timing
- Reset: A=1, B=0, `checksum`=32'h0000_0000, `checksum_valid`=0.
- Reset applies on the first rising edge with `rst`=1, including mid-message. A partial message is discarded and produces no `checksum_valid`.
- Throughput: one byte per cycle, sustained, with no stall.
- Latency: the last byte is sampled at edge N. `checksum` and `checksum_valid` are registered at edge N and visible for the cycle after it. `checksum_valid` drops at edge N+1 unless another last byte is accepted at N+1.
- Back-to-back messages are allowed. A last byte at edge N followed by a first byte at N+1 starts the new message from A=1, B=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `adler32_pkg`:
  - `ADLER_MOD` = 16'd65521.
  - `ADLER_A_INIT` = 16'd1.
  - `ADLER_B_INIT` = 16'd0.
- Sub-module `adler32_modadd`: combinational (a + b) mod 65521 for operands < 65521 (one 17-bit add and one conditional subtract). It is instantiated twice, chained A then B in the same cycle.
- The top level contains the A/B registers, completion logic and output registers. No FSM is needed beyond the implicit "in message" state.

## Test plan
- "Hello" (72,101,108,108,111) with random 0–9 cycle gaps between bytes -> one `checksum_valid` pulse, `checksum`=32'h058C01F5.
- Single byte "a" (97) with `last_data` -> 32'h00620062.
- "Wikipedia" sent back-to-back at full rate -> 32'h11E60398.
- 300 bytes of 8'hFF, which exercises modulo wrap in A and B -> 32'hB90F2AE4.
- "Hello" sent twice with no idle cycle between the messages -> two pulses, both 32'h058C01F5.
- `rst` asserted after 3 bytes, then "a" sent -> no pulse for the aborted message; `checksum` reads 0 after reset, then 32'h00620062.
